if_fetch_stage: RTL

- Instruction-fetch stage that sits directly upstream of the decode stage.
- Holds the PC and drives the instruction SRAM, which has 1-cycle read latency.
- Produces the {ce, pc} IF-to-ID bus and a stall-stable instruction word.
- Replaces ad-hoc instruction holding in decode with a one-entry hold buffer, and latches branch redirects that arrive while the PC is frozen so no redirect is lost.

---
 rtl/if_fetch_stage.sv | 111 +++++++++++
 1 files changed

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the 1-cycle-latency instruction SRAM,
// keeps branch redirects that arrive while the PC is frozen, and holds the decode-side word under stall.
module if_fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
   parameter int          STALL_W  = 6
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [STALL_W-1:0] stall,
   input  logic [32:0]        br_bus,
   output logic               inst_sram_en,
   output logic [3:0]         inst_sram_wen,
   output logic [31:0]        inst_sram_addr,
   output logic [31:0]        inst_sram_wdata,
   input  logic [31:0]        inst_sram_rdata,
   output logic [32:0]        if_to_id_bus,
   output logic [31:0]        if_inst,
   output logic               dbg_hold_vld,
   output logic               dbg_redir_pend
);

   // Flow control is stall-based rather than valid/ready: stall[0] freezes the PC,
   // stall[1] freezes the IF/ID boundary; ce marks if_to_id_bus as carrying a real fetch.
   typedef enum logic {
      S_PASS = 1'b0,
      S_HOLD = 1'b1
   } hold_state_e;

   logic        br_e;
   logic [31:0] br_addr;
   logic [31:0] pc_q;
   logic [31:0] pc_d;
   logic        ce_q;
   logic        redir_pend_q;
   logic [31:0] redir_addr_q;
   hold_state_e state_q;
   logic [31:0] hold_inst_q;
   logic        unused_stall;

   assign br_e    = br_bus[32];
   assign br_addr = br_bus[31:0];

   // stall[2] only tells decode to bubble; the held word is kept either way.
   assign unused_stall = ^stall[STALL_W-1:2];

   always_comb begin
      pc_d = pc_q + 32'd4;
      if (br_e) begin
         pc_d = br_addr;
      end else if (redir_pend_q) begin
         pc_d = redir_addr_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         pc_q <= RESET_PC - 32'd4;
         ce_q <= 1'b0;
      end else if (!stall[0]) begin
         pc_q <= pc_d;
         ce_q <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         redir_pend_q <= 1'b0;
         redir_addr_q <= 32'd0;
      end else if (stall[0]) begin
         if (br_e) begin
            redir_pend_q <= 1'b1;
            redir_addr_q <= br_addr;
         end
      end else begin
         redir_pend_q <= 1'b0;
      end
   end

   // Capture only on entry to HOLD so later SRAM returns cannot overwrite the word decode owns.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= S_PASS;
         hold_inst_q <= 32'd0;
      end else begin
         case (state_q)
            S_PASS: begin
               if (stall[1]) begin
                  state_q     <= S_HOLD;
                  hold_inst_q <= inst_sram_rdata;
               end
            end
            S_HOLD: begin
               if (!stall[1]) begin
                  state_q <= S_PASS;
               end
            end
            default: state_q <= S_PASS;
         endcase
      end
   end

   assign inst_sram_en    = ce_q & ~stall[0];
   assign inst_sram_wen   = 4'b0000;
   assign inst_sram_addr  = ce_q ? pc_q : 32'd0;
   assign inst_sram_wdata = 32'd0;
   assign if_to_id_bus    = {ce_q, pc_q};
   assign if_inst         = (state_q == S_HOLD) ? hold_inst_q : inst_sram_rdata;
   assign dbg_hold_vld    = (state_q == S_HOLD);
   assign dbg_redir_pend  = redir_pend_q;

endmodule
